// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM port arbiter.
package sram_arb_pkg;

   // Address width of the payload struct; the arbiter masks down to its AddrWidth.
   localparam int unsigned SramAddrWidth = 17;
   localparam int unsigned SramDataWidth = 32;
   localparam int unsigned SramBeWidth   = 4;

   // Requester indices.
   localparam logic ReqCore = 1'b0;
   localparam logic ReqDma  = 1'b1;

   typedef struct packed {
      logic                     we;
      logic [SramBeWidth-1:0]   be;
      logic [SramAddrWidth-1:0] addr;
      logic [SramDataWidth-1:0] wdata;
      logic                     wcap;
   } sram_req_t;

   typedef struct packed {
      logic [SramDataWidth-1:0] rdata;
      logic                     rcap;
      logic                     err;
   } sram_rsp_t;

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// Small FIFO holding which requester owns each outstanding SRAM response.
module sram_arb_tag_fifo #(
   parameter int unsigned Width = 1,
   parameter int unsigned Depth = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic [CntW-1:0]  count;
   logic             do_push;
   logic             do_pop;

   // A push onto a full FIFO is only accepted together with a pop.
   always_comb begin
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      full    = (count == CntW'(Depth));
      empty   = (count == '0);
      rdata   = mem[rd_ptr];
   end

   // Tag storage; no reset needed since count qualifies every entry.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap modulo Depth; count tracks occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates a core and a DMA requester onto one SRAM port and routes responses back.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned AddrWidth      = SramAddrWidth,
   parameter int unsigned StarveLimit    = 4,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      rr_mode_i,
   input  logic [1:0] req_i,
   input  sram_req_t req_data_i [2],
   output logic [1:0] gnt_o,
   output logic [1:0] rvalid_o,
   output sram_rsp_t rsp_o,
   output logic      mem_req_o,
   input  logic      mem_gnt_i,
   output sram_req_t mem_o,
   input  logic      mem_rvalid_i,
   input  sram_rsp_t mem_rsp_i
);

   localparam int unsigned CntW = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;
   localparam logic [SramAddrWidth-1:0] AddrMask =
      SramAddrWidth'((64'd1 << AddrWidth) - 64'd1);

   logic [CntW-1:0] starve_cnt;
   logic            last_gnt;
   logic            err_unexp;
   logic            winner;
   logic            xfer;
   logic            rsp_ok;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_head;

   // Winner selection: fixed priority with starvation guard, or round-robin.
   always_comb begin
      winner = ReqCore;
      if (req_i == 2'b11) begin
         if (rr_mode_i)                              winner = ~last_gnt;
         else if (starve_cnt >= CntW'(StarveLimit)) winner = ReqDma;
      end else if (req_i[1]) begin
         winner = ReqDma;
      end
   end

   // Downstream request, grant fan-back and response routing.
   always_comb begin
      mem_req_o = ~rst_i & (|req_i) & ~(fifo_full & ~mem_rvalid_i);
      xfer      = mem_gnt_i & mem_req_o;
      gnt_o     = xfer ? ((winner == ReqDma) ? 2'b10 : 2'b01) : 2'b00;
      mem_o      = req_data_i[winner];
      mem_o.addr = req_data_i[winner].addr & AddrMask;
      rsp_ok    = ~rst_i & mem_rvalid_i & ~fifo_empty;
      rvalid_o  = rsp_ok ? ((fifo_head == ReqDma) ? 2'b10 : 2'b01) : 2'b00;
      rsp_o     = mem_rsp_i;
   end

   // Starvation counter, round-robin history and unexpected-response flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
         last_gnt   <= ReqDma;
         err_unexp  <= 1'b0;
      end else begin
         if (req_i[1] & ~gnt_o[1])
            starve_cnt <= (starve_cnt >= CntW'(StarveLimit)) ? starve_cnt
                                                             : starve_cnt + CntW'(1);
         else
            starve_cnt <= '0;
         if (xfer) last_gnt <= winner;
         err_unexp <= err_unexp | (mem_rvalid_i & fifo_empty);
      end
   end

   sram_arb_tag_fifo #(
      .Width (1),
      .Depth (MaxOutstanding)
   ) u_tag_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (xfer),
      .wdata (winner),
      .pop   (rsp_ok),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a queue-based model.
module tb_sram_port_arbiter;
   import sram_arb_pkg::*;

   localparam int unsigned SL = 4;
   localparam int unsigned MO = 2;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       rr_mode_i;
   logic [1:0] req_i;
   sram_req_t  req_data_i [2];
   logic [1:0] gnt_o;
   logic [1:0] rvalid_o;
   sram_rsp_t  rsp_o;
   logic       mem_req_o;
   logic       mem_gnt_i;
   sram_req_t  mem_o;
   logic       mem_rvalid_i;
   sram_rsp_t  mem_rsp_i;

   always #5 clk_i = ~clk_i;

   sram_port_arbiter #(
      .AddrWidth      (SramAddrWidth),
      .StarveLimit    (SL),
      .MaxOutstanding (MO)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rr_mode_i    (rr_mode_i),
      .req_i        (req_i),
      .req_data_i   (req_data_i),
      .gnt_o        (gnt_o),
      .rvalid_o     (rvalid_o),
      .rsp_o        (rsp_o),
      .mem_req_o    (mem_req_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_o        (mem_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rsp_i    (mem_rsp_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: outstanding owners in issue order.
   int m_q[$];
   int m_starve;
   int m_last;
   bit m_err;

   logic      mode;
   bit        use_stage;
   sram_req_t stage_req [2];
   sram_rsp_t stage_rsp;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic sram_req_t rand_req();
      sram_req_t r;
      r.we    = 1'($urandom);
      r.be    = 4'($urandom);
      r.addr  = SramAddrWidth'($urandom);
      r.wdata = $urandom;
      r.wcap  = 1'($urandom);
      return r;
   endfunction

   function automatic int model_winner(input logic [1:0] rq);
      if (rq == 2'b11) begin
         if (mode) return 1 - m_last;
         return (m_starve >= int'(SL)) ? 1 : 0;
      end
      return rq[1] ? 1 : 0;
   endfunction

   // One clock cycle: apply inputs, compare every output with the model, advance the model.
   task automatic cycle(input logic [1:0] rq, input logic mg, input logic mrv,
                        output logic [1:0] g);
      int         w;
      logic       exp_mreq;
      logic [1:0] eg;
      logic [1:0] erv;
      sram_req_t  exp_mem;
      @(negedge clk_i);
      rr_mode_i    = mode;
      req_i        = rq;
      mem_gnt_i    = mg;
      mem_rvalid_i = mrv;
      if (use_stage) begin
         req_data_i = stage_req;
         mem_rsp_i  = stage_rsp;
      end else begin
         req_data_i[0] = rand_req();
         req_data_i[1] = rand_req();
         mem_rsp_i     = {$urandom, 2'($urandom)};
      end
      #1;
      exp_mreq = (rq != 2'b00) && !((m_q.size() >= int'(MO)) && !mrv);
      w        = model_winner(rq);
      eg       = (mg && exp_mreq) ? 2'(1 << w) : 2'b00;
      erv      = (mrv && m_q.size() > 0) ? 2'(1 << m_q[0]) : 2'b00;
      check_eq("mem_req", 64'(mem_req_o), 64'(exp_mreq));
      check_eq("gnt", 64'(gnt_o), 64'(eg));
      check_eq("rvalid", 64'(rvalid_o), 64'(erv));
      check_eq("rsp", 64'(rsp_o), 64'(mem_rsp_i));
      check_eq("err_unexp", 64'(dut.err_unexp), 64'(m_err));
      if (rq != 2'b00) begin
         exp_mem = (w == 1) ? req_data_i[1] : req_data_i[0];
         check_eq("mem_o", 64'(mem_o), 64'(exp_mem));
      end
      g = gnt_o;
      if (mrv) begin
         if (m_q.size() > 0) void'(m_q.pop_front());
         else                m_err = 1'b1;
      end
      if (eg != 2'b00) begin
         m_q.push_back(w);
         m_last = w;
      end
      if (rq[1] && !eg[1]) m_starve = (m_starve < int'(SL)) ? m_starve + 1 : int'(SL);
      else                 m_starve = 0;
   endtask

   // Reset with all inputs active; outputs must stay quiet and the model clears.
   task automatic do_reset(input logic rr);
      @(negedge clk_i);
      mode          = rr;
      rr_mode_i     = rr;
      rst_i         = 1'b1;
      req_i         = 2'b11;
      mem_gnt_i     = 1'b1;
      mem_rvalid_i  = 1'b1;
      req_data_i[0] = rand_req();
      req_data_i[1] = rand_req();
      #1;
      check_eq("rst_gnt", 64'(gnt_o), 64'd0);
      check_eq("rst_mem_req", 64'(mem_req_o), 64'd0);
      check_eq("rst_rvalid", 64'(rvalid_o), 64'd0);
      check_eq("rst_err", 64'(dut.err_unexp), 64'd0);
      @(negedge clk_i);
      rst_i        = 1'b0;
      req_i        = 2'b00;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      m_q.delete();
      m_starve = 0;
      m_last   = 1;
      m_err    = 1'b0;
   endtask

   initial begin
      logic [1:0] g;
      logic [1:0] fixed_pat [10];
      logic [1:0] rq;
      logic       mg;
      logic       mrv;

      rst_i        = 1'b1;
      mode         = 1'b0;
      use_stage    = 1'b0;
      rr_mode_i    = 1'b0;
      req_i        = 2'b00;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rsp_i    = '0;
      m_starve     = 0;
      m_last       = 1;
      m_err        = 1'b0;
      fixed_pat    = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

      // Single core read: same-cycle grant, response routed to the core.
      do_reset(1'b0);
      cycle(2'b00, 1'b0, 1'b0, g);
      cycle(2'b01, 1'b1, 1'b0, g);
      check_eq("single_gnt", 64'(g), 64'(2'b01));
      cycle(2'b00, 1'b0, 1'b1, g);
      check_eq("single_rvalid", 64'(rvalid_o), 64'(2'b01));

      // Fixed priority with both requesting: DMA forced through every fifth cycle.
      do_reset(1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(2'b11, 1'b1, 1'(m_q.size() > 0), g);
         check_eq("fixed_pat", 64'(g), 64'(fixed_pat[i]));
      end

      // Round-robin alternation starting with the core.
      do_reset(1'b1);
      for (int i = 0; i < 6; i++) begin
         cycle(2'b11, 1'b1, 1'(m_q.size() > 0), g);
         check_eq("rr_pat", 64'(g), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      end

      // Full routing FIFO stalls the third request until a response frees a slot.
      do_reset(1'b0);
      cycle(2'b01, 1'b1, 1'b0, g);
      cycle(2'b01, 1'b1, 1'b0, g);
      cycle(2'b01, 1'b1, 1'b0, g);
      check_eq("full_mem_req", 64'(mem_req_o), 64'd0);
      cycle(2'b01, 1'b1, 1'b1, g);
      check_eq("full_pop_mem_req", 64'(mem_req_o), 64'd1);
      check_eq("full_pop_gnt", 64'(g), 64'(2'b01));
      check_eq("full_pop_rvalid", 64'(rvalid_o), 64'(2'b01));

      // Interleaved reads with latency 3, responses routed by owner.
      do_reset(1'b0);
      use_stage          = 1'b1;
      stage_req[0]       = '{we: 1'b0, be: 4'hf, addr: SramAddrWidth'(32'h100), wdata: '0, wcap: 1'b0};
      stage_req[1]       = '{we: 1'b0, be: 4'hf, addr: SramAddrWidth'(32'h200), wdata: '0, wcap: 1'b0};
      stage_rsp          = '0;
      cycle(2'b01, 1'b1, 1'b0, g);
      check_eq("il_addr0", 64'(mem_o.addr), 64'h100);
      cycle(2'b10, 1'b1, 1'b0, g);
      check_eq("il_addr1", 64'(mem_o.addr), 64'h200);
      cycle(2'b00, 1'b0, 1'b0, g);
      stage_rsp.rdata = 32'hAAAA_0100;
      cycle(2'b00, 1'b0, 1'b1, g);
      check_eq("il_rv0", 64'(rvalid_o), 64'(2'b01));
      check_eq("il_rdata0", 64'(rsp_o.rdata), 64'hAAAA_0100);
      stage_rsp.rdata = 32'hBBBB_0200;
      cycle(2'b00, 1'b0, 1'b1, g);
      check_eq("il_rv1", 64'(rvalid_o), 64'(2'b10));
      check_eq("il_rdata1", 64'(rsp_o.rdata), 64'hBBBB_0200);
      use_stage = 1'b0;

      // Reset with tags outstanding; a late response is unexpected.
      do_reset(1'b0);
      cycle(2'b01, 1'b1, 1'b0, g);
      cycle(2'b10, 1'b1, 1'b0, g);
      do_reset(1'b0);
      cycle(2'b00, 1'b0, 1'b1, g);
      check_eq("late_rvalid", 64'(rvalid_o), 64'd0);
      cycle(2'b00, 1'b0, 1'b0, g);
      check_eq("late_err", 64'(dut.err_unexp), 64'd1);

      // Randomized traffic in both modes with legal in-order responses.
      for (int blk = 0; blk < 6; blk++) begin
         do_reset(1'(blk % 2));
         for (int i = 0; i < 150; i++) begin
            rq  = 2'($urandom);
            mg  = 1'(($urandom % 4) != 0);
            mrv = 1'((m_q.size() > 0) && ($urandom % 2 == 1));
            if (i == 75) mode = ~mode;
            cycle(rq, mg, mrv, g);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
